tape_prefetch: RTL
==================

TAPE_PREFETCH -- requirements
Module: tape_prefetch

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO depth in bytes (power of 2, 4..32).
REQ-002 SHALL have parameter AW, default 23, meaning byte-address width.
REQ-003 SHALL have clock port clk, input, 1, meaning the single clock, same clock as the SDRAM controller.
REQ-004 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port ld, input, 1, meaning a one-cycle pulse that loads a new playback window.
REQ-006 SHALL have port ld_addr, input, AW, meaning the first byte address of the window.
REQ-007 SHALL have port end_addr, input, AW, meaning the exclusive end address, sampled on ld.
REQ-008 SHALL have port pop, input, 1, meaning the consumer takes the head byte this cycle.
REQ-009 SHALL have port dout, output, 8, meaning the show-ahead FIFO head, 8'hFF when empty.
REQ-010 SHALL have ports empty and done, output, 1 each; done means the window is exhausted and the FIFO is empty.
REQ-011 SHALL have ports wr_req, wr_addr[AW], wr_data[8], input, meaning the loader byte-write request (level), and wr_busy, output, 1.
REQ-012 SHALL have ports tape_addr[AW], tape_din[8], tape_rd, tape_wr, output, to the SDRAM controller tape port.
REQ-013 SHALL have ports tape_dout[8] and tape_ack (toggle), input, from the SDRAM controller tape port.

Function
REQ-014 SHALL run an FSM with states IDLE, RD_WAIT and WR_WAIT.
REQ-015 SHALL detect ack as tape_ack XOR ack_q, where ack_q is a registered copy of tape_ack.
REQ-016 IDLE SHALL enter WR_WAIT when wr_req=1; write has priority over prefetch.
REQ-017 Otherwise, IDLE SHALL enter RD_WAIT when fetch_addr<end_addr and count<DEPTH.
REQ-018 On entry to RD_WAIT or WR_WAIT, the block SHALL register tape_addr and tape_din, and assert tape_rd or tape_wr as a level.
REQ-019 The request SHALL be held until the ack-detect cycle; tape_rd/tape_wr SHALL deassert on the cycle after that, returning to IDLE.
REQ-020 At most one request SHALL be outstanding at any time.
REQ-021 On RD_WAIT ack, tape_dout SHALL be pushed into the FIFO and fetch_addr SHALL increment by 1, unless the discard flag is set.
REQ-022 On WR_WAIT ack, wr_busy SHALL drop for exactly one cycle so the loader advances.
REQ-023 wr_busy SHALL be 1 whenever wr_req=1 and the write is not acked.
REQ-024 pop while empty SHALL be ignored.
REQ-025 A simultaneous push and pop SHALL leave count unchanged and data in order.
REQ-026 A push SHALL never occur at count=DEPTH (guaranteed by REQ-017).
REQ-027 Pointers SHALL wrap modulo DEPTH, and count SHALL be log2(DEPTH)+1 bits.
REQ-028 A pushed byte SHALL appear on dout on the next cycle when the FIFO was previously empty.
REQ-029 ld SHALL flush the FIFO (count=0), set fetch_addr=ld_addr, and latch end_addr.
REQ-030 If ld arrives during RD_WAIT, the block SHALL set discard, await that ack, and drop its byte.
REQ-031 ld during WR_WAIT SHALL NOT abort the write.
REQ-032 ld_addr>=end_addr SHALL give done=1 on the next cycle with no requests issued.
REQ-033 done SHALL equal (fetch_addr>=end_addr) AND empty AND state==IDLE.
REQ-034 fetch_addr SHALL saturate at end_addr and never wrap.

Reset
REQ-035 Reset SHALL force state IDLE, tape_rd=0, tape_wr=0, count=0, pointers=0, discard=0, fetch_addr=0, end_addr=0, tape_addr=0, tape_din=0.
REQ-036 Reset SHALL force empty=1, done=1, dout=8'hFF, wr_busy=wr_req.
REQ-037 Reset SHALL load ack_q<=tape_ack so that no false ack is seen.
REQ-038 Reset mid-request SHALL abandon it; a late toggle SHALL be absorbed by the ack_q resync and never pushed.

Structure
REQ-039 The state encodings and tape bank number SHALL live in a shared package with the SDRAM constants.
REQ-040 The FIFO SHALL be one sub-module, tape_fifo (show-ahead, count output); all else SHALL be in tape_prefetch.

Verification
REQ-041 Test: ld_addr=0x100, end_addr=0x104, no pops, model acks after 8 cycles -> exactly 4 tape_rd requests at 0x100..0x103, count=4, then idle.
REQ-042 Test: ld_addr=0, end_addr=0x40, DEPTH=8, no pops -> requests stop at count=8; one pop -> exactly one further request at 0x08.
REQ-043 Test: wr_req held with wr_addr=0x200, wr_data=0x5A during prefetch -> the current read completes, then tape_wr with tape_din=0x5A; wr_busy falls one cycle after ack.
REQ-044 Test: ld to 0x300 during RD_WAIT on 0x010 -> the 0x010 byte is discarded, the FIFO stays empty, and the next request is 0x300.
REQ-045 Test: pop and ack-push in the same cycle at count=3 -> count stays 3 and the byte order matches the address order.
REQ-046 Test: reset asserted in RD_WAIT, ack toggles one cycle later -> no push occurs, tape_rd=0, empty=1, done=1.

Source files
------------

// File: rtl/tape_prefetch_pkg.sv
// rtl/tape_prefetch_pkg.sv - shared SDRAM constants, tape bank and prefetch FSM encoding
package tape_prefetch_pkg;

  localparam int         SDRAM_AW   = 23;
  localparam logic [1:0] TAPE_BANK  = 2'd3;
  localparam logic [7:0] EMPTY_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2
  } tp_state_t;

  function automatic int fifo_count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/tape_fifo.sv
// rtl/tape_fifo.sv - show-ahead byte FIFO with occupancy count and synchronous flush
module tape_fifo
  import tape_prefetch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             push,
  input  logic [7:0]                       din,
  input  logic                             pop,
  output logic [7:0]                       dout,
  output logic                             empty,
  output logic [fifo_count_w(DEPTH)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_empty;
  logic          w_pop;

  assign w_empty = (r_count == '0);
  assign w_pop   = pop && !w_empty;

  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head is visible combinationally so a byte shows up the cycle after its push.
  assign dout  = w_empty ? EMPTY_BYTE : r_mem[r_rd_ptr];
  assign empty = w_empty;
  assign count = r_count;

endmodule

// File: rtl/tape_prefetch.sv
// rtl/tape_prefetch.sv - tape playback prefetcher: window fetch over the SDRAM tape port into a byte FIFO
module tape_prefetch
  import tape_prefetch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = SDRAM_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld,
  input  logic [AW-1:0] ld_addr,
  input  logic [AW-1:0] end_addr,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic          empty,
  output logic          done,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  output logic          wr_busy,
  output logic [AW-1:0] tape_addr,
  output logic [7:0]    tape_din,
  output logic          tape_rd,
  output logic          tape_wr,
  input  logic [7:0]    tape_dout,
  input  logic          tape_ack
);
  localparam int            CW   = fifo_count_w(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  tp_state_t     r_state;
  tp_state_t     w_state_nxt;
  logic          r_ack_q;
  logic          r_discard;
  logic          r_wr_done;
  logic [AW-1:0] r_fetch_addr;
  logic [AW-1:0] r_end_addr;
  logic [AW-1:0] r_tape_addr;
  logic [7:0]    r_tape_din;
  logic          r_tape_rd;
  logic          r_tape_wr;

  logic [CW-1:0] w_count;
  logic          w_fifo_empty;
  logic          w_ack;
  logic          w_wr_pending;
  logic          w_fetch_ok;
  logic          w_start_rd;
  logic          w_start_wr;
  logic          w_push;

  assign w_ack = tape_ack ^ r_ack_q;
  // The cycle after a write ack still shows the old request; don't replay it.
  assign w_wr_pending = wr_req && !r_wr_done;
  assign w_fetch_ok   = (r_fetch_addr < r_end_addr) && (w_count < FULL) && !ld;

  always_comb begin
    w_state_nxt = r_state;
    w_start_rd  = 1'b0;
    w_start_wr  = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_wr_pending) begin
          w_state_nxt = ST_WR_WAIT;
          w_start_wr  = 1'b1;
        end else if (w_fetch_ok) begin
          w_state_nxt = ST_RD_WAIT;
          w_start_rd  = 1'b1;
        end
      end
      ST_RD_WAIT: begin
        if (w_ack) begin
          w_state_nxt = ST_IDLE;
          w_push      = !r_discard && !ld;
        end
      end
      ST_WR_WAIT: begin
        if (w_ack) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack_q      <= tape_ack;
      r_discard    <= 1'b0;
      r_wr_done    <= 1'b0;
      r_fetch_addr <= '0;
      r_end_addr   <= '0;
      r_tape_addr  <= '0;
      r_tape_din   <= '0;
      r_tape_rd    <= 1'b0;
      r_tape_wr    <= 1'b0;
    end else begin
      r_ack_q   <= tape_ack;
      r_wr_done <= 1'b0;
      if (w_start_rd) begin
        r_tape_addr <= r_fetch_addr;
        r_tape_rd   <= 1'b1;
      end
      if (w_start_wr) begin
        r_tape_addr <= wr_addr;
        r_tape_din  <= wr_data;
        r_tape_wr   <= 1'b1;
      end
      // A reload while a read is in flight marks that byte as stale.
      if (w_ack && (r_state == ST_RD_WAIT)) begin
        r_tape_rd <= 1'b0;
        r_discard <= 1'b0;
      end else if (ld && (r_state == ST_RD_WAIT)) begin
        r_discard <= 1'b1;
      end
      if (w_ack && (r_state == ST_WR_WAIT)) begin
        r_tape_wr <= 1'b0;
        r_wr_done <= 1'b1;
      end
      if (ld) begin
        r_fetch_addr <= ld_addr;
        r_end_addr   <= end_addr;
      end else if (w_push) begin
        r_fetch_addr <= r_fetch_addr + 1'b1;
      end
    end
  end

  tape_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (ld),
    .push  (w_push),
    .din   (tape_dout),
    .pop   (pop),
    .dout  (dout),
    .empty (w_fifo_empty),
    .count (w_count)
  );

  assign empty     = w_fifo_empty;
  assign done      = (r_fetch_addr >= r_end_addr) && w_fifo_empty && (r_state == ST_IDLE);
  assign wr_busy   = wr_req && !r_wr_done;
  assign tape_addr = r_tape_addr;
  assign tape_din  = r_tape_din;
  assign tape_rd   = r_tape_rd;
  assign tape_wr   = r_tape_wr;

endmodule
